// File: rtl/collision_scan_ctrl.sv
// collision_scan_ctrl: once per frame, scans every car slot through a single AABB
// overlap checker (one car per cycle) and reports the lowest-numbered colliding car.
// It also sequences death, respawn, lives and game over.
// Latency: a scan occupies NUM_CARS cycles after the tick, then one REPORT cycle,
// so o_Hit appears NUM_CARS+1 cycles after i_Frame_Tick.
// Frame ticks that arrive while busy, in DEAD (except for counting) or in GAME_OVER
// are dropped; nothing is queued.
// Ports:
//   i_Clk, i_Rst_N                 clock, async active-low reset
//   i_Frame_Tick, i_Restart        frame pulse, leave-game-over request
//   i_Frog_X/Y, i_Car_X/Y_Flat     frog position, packed car positions (10 bits each)
//   o_Scan_Busy, o_Hit, o_Hit_Car  scan status, hit pulse, colliding car index
//   o_Frog_Freeze, o_Respawn       frog freeze level, respawn pulse
//   o_Lives, o_Game_Over           remaining lives, game-over level
module collision_scan_ctrl #(
  parameter int TILE_SIZE      = 32,
  parameter int NUM_CARS       = 4,
  parameter int RESPAWN_FRAMES = 60,
  parameter int LIVES          = 3
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_N,
  input  logic                    i_Frame_Tick,
  input  logic                    i_Restart,
  input  logic [9:0]              i_Frog_X,
  input  logic [9:0]              i_Frog_Y,
  input  logic [10*NUM_CARS-1:0]  i_Car_X_Flat,
  input  logic [10*NUM_CARS-1:0]  i_Car_Y_Flat,
  output logic                    o_Scan_Busy,
  output logic                    o_Hit,
  output logic [3:0]              o_Hit_Car,
  output logic                    o_Frog_Freeze,
  output logic                    o_Respawn,
  output logic [3:0]              o_Lives,
  output logic                    o_Game_Over
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REPORT, S_DEAD, S_OVER} state_t;

  localparam logic [3:0]  LAST_IDX  = 4'(NUM_CARS - 1);
  localparam logic [7:0]  RESP_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [3:0]  LIVES_INI = 4'(LIVES);
  localparam logic [10:0] TS        = 11'(TILE_SIZE);

  state_t      state, state_n;
  logic [9:0]  frog_x, frog_y;
  logic [3:0]  idx;
  logic        hit_flag;
  logic [3:0]  hit_idx;
  logic [3:0]  hit_car;
  logic [3:0]  lives;
  logic [7:0]  resp_cnt;
  logic        respawn;

  // Car coordinates are taken live in their check cycle; frog comes from the snapshot.
  // Sums are 11 bits wide so a sprite near X=1023 cannot wrap into a false overlap.
  logic [10:0] fx, fy, cx, cy;
  logic        overlap;

  always_comb begin
    fx = {1'b0, frog_x};
    fy = {1'b0, frog_y};
    cx = {1'b0, i_Car_X_Flat[idx*10 +: 10]};
    cy = {1'b0, i_Car_Y_Flat[idx*10 +: 10]};
    // Strict inequalities: sprites that only share an edge do not collide.
    overlap = (fx < cx + TS) && (cx < fx + TS) &&
              (fy < cy + TS) && (cy < fy + TS);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (i_Frame_Tick) state_n = S_SCAN;
      S_SCAN:   if (idx == LAST_IDX) state_n = S_REPORT;
      S_REPORT: begin
        if (hit_flag) state_n = (lives <= 4'd1) ? S_OVER : S_DEAD;
        else          state_n = S_IDLE;
      end
      // The tick that ends DEAD is consumed here, so it cannot also start a scan.
      S_DEAD:   if (i_Frame_Tick && resp_cnt == RESP_LAST) state_n = S_IDLE;
      S_OVER:   if (i_Restart) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      frog_x   <= '0;
      frog_y   <= '0;
      idx      <= '0;
      hit_flag <= 1'b0;
      hit_idx  <= '0;
      hit_car  <= '0;
      lives    <= LIVES_INI;
      resp_cnt <= '0;
      respawn  <= 1'b0;
    end else begin
      respawn <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Frame_Tick) begin
            frog_x   <= i_Frog_X;
            frog_y   <= i_Frog_Y;
            idx      <= '0;
            hit_flag <= 1'b0;
          end
        end
        S_SCAN: begin
          // Only the first overlapping slot is kept; the scan still runs to the end.
          if (overlap && !hit_flag) begin
            hit_flag <= 1'b1;
            hit_idx  <= idx;
          end
          if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
        S_REPORT: begin
          if (hit_flag) begin
            hit_car  <= hit_idx;
            if (lives != 4'd0) lives <= lives - 4'd1;
            resp_cnt <= '0;
          end
        end
        S_DEAD: begin
          if (i_Frame_Tick) begin
            resp_cnt <= resp_cnt + 8'd1;
            respawn  <= (resp_cnt == RESP_LAST);
          end
        end
        S_OVER: begin
          if (i_Restart) lives <= LIVES_INI;
        end
        default: ;
      endcase
    end
  end

  // o_Hit_Car shows the new index during the hit cycle and then holds the stored one.
  always_comb begin
    o_Scan_Busy   = (state == S_SCAN) || (state == S_REPORT);
    o_Hit         = (state == S_REPORT) && hit_flag;
    o_Hit_Car     = o_Hit ? hit_idx : hit_car;
    o_Frog_Freeze = (state == S_DEAD) || (state == S_OVER);
    o_Game_Over   = (state == S_OVER);
    o_Respawn     = respawn;
    o_Lives       = lives;
  end

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Bench for collision_scan_ctrl (NUM_CARS=4, RESPAWN_FRAMES=2, LIVES=3).
// Expected hits and respawns go into queues when stimulus is issued; a monitor
// pops them whenever the DUT pulses o_Hit / o_Respawn.
module tb_collision_scan_ctrl;

  localparam int NC = 4;

  logic          i_Clk = 1'b0;
  logic          i_Rst_N = 1'b0;
  logic          i_Frame_Tick = 1'b0;
  logic          i_Restart = 1'b0;
  logic [9:0]    i_Frog_X = '0;
  logic [9:0]    i_Frog_Y = '0;
  logic [10*NC-1:0] i_Car_X_Flat = '0;
  logic [10*NC-1:0] i_Car_Y_Flat = '0;
  logic          o_Scan_Busy, o_Hit, o_Frog_Freeze, o_Respawn, o_Game_Over;
  logic [3:0]    o_Hit_Car, o_Lives;

  int errors = 0;
  int checks = 0;
  int exp_hit_q[$];
  int exp_resp_q[$];

  collision_scan_ctrl #(
    .TILE_SIZE(32), .NUM_CARS(NC), .RESPAWN_FRAMES(2), .LIVES(3)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_N(i_Rst_N), .i_Frame_Tick(i_Frame_Tick), .i_Restart(i_Restart),
    .i_Frog_X(i_Frog_X), .i_Frog_Y(i_Frog_Y),
    .i_Car_X_Flat(i_Car_X_Flat), .i_Car_Y_Flat(i_Car_Y_Flat),
    .o_Scan_Busy(o_Scan_Busy), .o_Hit(o_Hit), .o_Hit_Car(o_Hit_Car),
    .o_Frog_Freeze(o_Frog_Freeze), .o_Respawn(o_Respawn),
    .o_Lives(o_Lives), .o_Game_Over(o_Game_Over)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every o_Hit / o_Respawn must match a queued expectation.
  always @(negedge i_Clk) begin
    if (i_Rst_N && o_Hit) begin
      if (exp_hit_q.size() == 0) chk("unexpected_hit", 1, 0);
      else chk("hit_car", int'(o_Hit_Car), exp_hit_q.pop_front());
    end
    if (i_Rst_N && o_Respawn) begin
      if (exp_resp_q.size() == 0) chk("unexpected_respawn", 1, 0);
      else chk("respawn", 1, exp_resp_q.pop_front());
    end
  end

  task automatic set_car(input int k, input int x, input int y);
    i_Car_X_Flat[k*10 +: 10] = 10'(x);
    i_Car_Y_Flat[k*10 +: 10] = 10'(y);
  endtask

  task automatic park_cars();
    for (int k = 0; k < NC; k++) set_car(k, 600, 400);
  endtask

  // One tick pulse, then enough idle cycles for scan/report to complete.
  task automatic frame(output logic busy1);
    i_Frame_Tick = 1'b1;
    @(posedge i_Clk); #1;
    i_Frame_Tick = 1'b0;
    @(negedge i_Clk);
    busy1 = o_Scan_Busy;
    repeat (7) @(posedge i_Clk);
    #1;
  endtask

  // Two DEAD ticks: the first only counts, the second respawns.
  task automatic respawn_seq();
    logic b;
    frame(b);
    chk("dead_tick1_no_scan", int'(b), 0);
    chk("dead_tick1_freeze", int'(o_Frog_Freeze), 1);
    exp_resp_q.push_back(1);
    frame(b);
    chk("dead_tick2_no_scan", int'(b), 0);
    chk("after_respawn_freeze", int'(o_Frog_Freeze), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    park_cars();
    i_Frog_X = 10'd100; i_Frog_Y = 10'd200;
    repeat (3) @(posedge i_Clk);
    #1 i_Rst_N = 1'b1;
    @(posedge i_Clk); #1;

    // Reset state
    chk("rst_lives", int'(o_Lives), 3);
    chk("rst_hit_car", int'(o_Hit_Car), 0);
    chk("rst_busy", int'(o_Scan_Busy), 0);
    chk("rst_hit", int'(o_Hit), 0);
    chk("rst_freeze", int'(o_Frog_Freeze), 0);
    chk("rst_respawn", int'(o_Respawn), 0);
    chk("rst_game_over", int'(o_Game_Over), 0);

    // Basic hit: car1 overlaps, tick at cycle 0
    set_car(1, 110, 200);
    exp_hit_q.push_back(1);
    i_Frame_Tick = 1'b1;
    @(posedge i_Clk); #1;
    i_Frame_Tick = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge i_Clk);
      chk($sformatf("busy_cyc%0d", c), int'(o_Scan_Busy), (c <= 5) ? 1 : 0);
      chk($sformatf("hit_cyc%0d", c), int'(o_Hit), (c == 5) ? 1 : 0);
      chk($sformatf("freeze_cyc%0d", c), int'(o_Frog_Freeze), (c == 6) ? 1 : 0);
      if (c == 6) chk("lives_after_hit1", int'(o_Lives), 2);
      @(posedge i_Clk); #1;
    end
    park_cars();
    respawn_seq();
    frame(b);
    chk("third_tick_scans", int'(b), 1);
    chk("hit_car_held", int'(o_Hit_Car), 1);

    // Edge contact: no hit; corner overlap by one pixel: hit
    set_car(0, 132, 200);
    frame(b);
    chk("edge_lives", int'(o_Lives), 2);
    set_car(0, 131, 231);
    exp_hit_q.push_back(0);
    frame(b);
    chk("corner_lives", int'(o_Lives), 1);
    park_cars();
    respawn_seq();

    // Wrap safety near X=1023
    i_Frog_X = 10'd1000; i_Frog_Y = 10'd0;
    set_car(0, 5, 0);
    frame(b);
    chk("wrap_nohit_lives", int'(o_Lives), 1);
    chk("wrap_nohit_freeze", int'(o_Frog_Freeze), 0);
    set_car(0, 1010, 0);
    exp_hit_q.push_back(0);
    frame(b);
    chk("go_lives", int'(o_Lives), 0);
    chk("go_flag", int'(o_Game_Over), 1);
    chk("go_freeze", int'(o_Frog_Freeze), 1);
    frame(b);  // ignored in GAME_OVER; still overlapping, so any scan would hit
    chk("go_tick_no_scan", int'(b), 0);
    chk("go_lives_hold", int'(o_Lives), 0);

    // Restart together with a tick
    i_Restart = 1'b1; i_Frame_Tick = 1'b1;
    @(posedge i_Clk); #1;
    i_Restart = 1'b0; i_Frame_Tick = 1'b0;
    @(negedge i_Clk);
    chk("restart_busy", int'(o_Scan_Busy), 0);
    chk("restart_lives", int'(o_Lives), 3);
    chk("restart_go", int'(o_Game_Over), 0);
    chk("restart_freeze", int'(o_Frog_Freeze), 0);
    @(posedge i_Clk); #1;

    // Multiple overlaps: cars 2 and 3, lowest wins, one decrement
    park_cars();
    i_Frog_X = 10'd100; i_Frog_Y = 10'd200;
    set_car(2, 110, 200);
    set_car(3, 100, 210);
    exp_hit_q.push_back(2);
    frame(b);
    chk("multi_lives", int'(o_Lives), 2);
    chk("multi_hit_car", int'(o_Hit_Car), 2);
    park_cars();
    respawn_seq();

    // Reset mid-scan (scan cycle 2): no hit, everything back to reset values
    set_car(1, 110, 200);
    i_Frame_Tick = 1'b1;
    @(posedge i_Clk); #1;
    i_Frame_Tick = 1'b0;
    @(posedge i_Clk); #1;
    i_Rst_N = 1'b0;
    #1;
    chk("midrst_busy", int'(o_Scan_Busy), 0);
    chk("midrst_lives", int'(o_Lives), 3);
    chk("midrst_hit_car", int'(o_Hit_Car), 0);
    repeat (2) @(posedge i_Clk);
    #1 i_Rst_N = 1'b1;
    repeat (8) @(posedge i_Clk);
    #1;
    chk("postrst_busy", int'(o_Scan_Busy), 0);
    chk("postrst_freeze", int'(o_Frog_Freeze), 0);
    chk("postrst_lives", int'(o_Lives), 3);
    chk("postrst_go", int'(o_Game_Over), 0);

    chk("hit_queue_empty", exp_hit_q.size(), 0);
    chk("resp_queue_empty", exp_resp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
